// File: rtl/bcd_delta_tracker_pkg.sv
// rtl/bcd_delta_tracker_pkg.sv - shared types and helpers for the BCD delta tracker
package bcd_delta_tracker_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        EMPTY,
        IDLE,
        CALC,
        HOLD
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] huns;
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd3_t;

    function automatic logic is_bcd(input bcd3_t v);
        return (v.huns <= DIGIT_MAX) && (v.tens <= DIGIT_MAX) && (v.ones <= DIGIT_MAX);
    endfunction

    function automatic logic [9:0] bcd_to_bin(input bcd3_t v);
        return 10'(v.huns) * 10'd100 + 10'(v.tens) * 10'd10 + 10'(v.ones);
    endfunction

endpackage

// File: rtl/bcd_delta_tracker_subtractor.sv
// rtl/bcd_delta_tracker_subtractor.sv - combinational |y - x| in 3-digit BCD with sign
import bcd_delta_tracker_pkg::*;

module bcd_subtractor (
    input  bcd3_t x,
    input  bcd3_t y,
    output bcd3_t diff,
    output logic  neg
);

    logic [9:0] x_bin;
    logic [9:0] y_bin;
    logic [9:0] mag;

    always_comb begin
        x_bin = bcd_to_bin(x);
        y_bin = bcd_to_bin(y);
        neg   = (y_bin < x_bin);
        mag   = neg ? (x_bin - y_bin) : (y_bin - x_bin);
        // Inputs are pre-checked BCD, so mag never exceeds 999.
        diff.huns = DIGIT_W'(mag / 10'd100);
        diff.tens = DIGIT_W'((mag / 10'd10) % 10'd10);
        diff.ones = DIGIT_W'(mag % 10'd10);
    end

endmodule

// File: rtl/bcd_delta_tracker.sv
// rtl/bcd_delta_tracker.sv - tracks successive BCD samples and emits their signed difference
import bcd_delta_tracker_pkg::*;

module bcd_delta_tracker #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [3:0]         s_ones,
    input  logic [3:0]         s_tens,
    input  logic [3:0]         s_huns,
    output logic               d_valid,
    input  logic               d_ready,
    output logic [3:0]         d_ones,
    output logic [3:0]         d_tens,
    output logic [3:0]         d_huns,
    output logic               d_neg,
    output logic               bcd_err,
    output logic [CNT_W-1:0]   d_count
);

    state_t state;
    bcd3_t  ref_r;
    bcd3_t  new_r;
    bcd3_t  d_r;
    bcd3_t  sample;
    bcd3_t  sub_diff;
    logic   sub_neg;
    logic   accept;

    assign sample  = '{huns: s_huns, tens: s_tens, ones: s_ones};
    assign s_ready = ((state == EMPTY) || (state == IDLE)) && !clear;
    assign accept  = s_valid && s_ready;
    assign d_huns  = d_r.huns;
    assign d_tens  = d_r.tens;
    assign d_ones  = d_r.ones;

    bcd_subtractor u_sub (
        .x    (ref_r),
        .y    (new_r),
        .diff (sub_diff),
        .neg  (sub_neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            ref_r   <= '0;
            new_r   <= '0;
            d_r     <= '0;
            d_neg   <= 1'b0;
            d_valid <= 1'b0;
            bcd_err <= 1'b0;
            d_count <= '0;
        end else begin
            bcd_err <= 1'b0;
            if (clear) begin
                state   <= EMPTY;
                d_valid <= 1'b0;
                d_neg   <= 1'b0;
                d_count <= '0;
            end else begin
                case (state)
                    EMPTY, IDLE: begin
                        // A malformed sample is dropped without touching state or reference.
                        if (accept) begin
                            if (!is_bcd(sample)) begin
                                bcd_err <= 1'b1;
                            end else if (state == EMPTY) begin
                                ref_r <= sample;
                                state <= IDLE;
                            end else begin
                                new_r <= sample;
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        d_r     <= sub_diff;
                        d_neg   <= sub_neg;
                        ref_r   <= new_r;
                        d_valid <= 1'b1;
                        state   <= HOLD;
                    end
                    HOLD: begin
                        if (d_ready) begin
                            d_valid <= 1'b0;
                            state   <= IDLE;
                            if (d_count != {CNT_W{1'b1}}) begin
                                d_count <= d_count + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_delta_tracker.sv
// tb/tb_bcd_delta_tracker.sv - self-checking bench for bcd_delta_tracker
module tb_bcd_delta_tracker;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             s_valid;
    logic             s_ready;
    logic [3:0]       s_ones, s_tens, s_huns;
    logic             d_valid;
    logic             d_ready;
    logic [3:0]       d_ones, d_tens, d_huns;
    logic             d_neg;
    logic             bcd_err;
    logic [CNT_W-1:0] d_count;
    logic [11:0]      d_obs;

    int n_checks = 0;
    int n_pass   = 0;
    int m_ref    = 0;
    bit m_has_ref = 0;
    int m_count  = 0;

    assign d_obs = {d_huns, d_tens, d_ones};

    always #5 clk = ~clk;

    bcd_delta_tracker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_ones(s_ones), .s_tens(s_tens), .s_huns(s_huns),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_ones(d_ones), .d_tens(d_tens), .d_huns(d_huns),
        .d_neg(d_neg), .bcd_err(bcd_err), .d_count(d_count)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int to_int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [11:0] s, output logic err);
        {s_huns, s_tens, s_ones} = s;
        s_valid = 1'b1;
        next_cycle();
        s_valid = 1'b0;
        err = bcd_err;
    endtask

    task automatic handshake();
        d_ready = 1'b1;
        next_cycle();
        d_ready = 1'b0;
        m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        m_count = 0;
        m_has_ref = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; d_ready = 1'b0;
        s_ones = '0; s_tens = '0; s_huns = '0;
        #13;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got=%b exp=1", s_ready); else n_pass++;
        n_checks++; if (d_valid !== 1'b0) $display("FAIL reset_d_valid got=%b exp=0", d_valid); else n_pass++;
        n_checks++; if (d_obs !== 12'h000) $display("FAIL reset_d got=%h exp=000", d_obs); else n_pass++;
        n_checks++; if (d_neg !== 1'b0) $display("FAIL reset_d_neg got=%b exp=0", d_neg); else n_pass++;
        n_checks++; if (bcd_err !== 1'b0) $display("FAIL reset_bcd_err got=%b exp=0", bcd_err); else n_pass++;
        n_checks++; if (d_count !== '0) $display("FAIL reset_d_count got=%0d exp=0", d_count); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        m_count = 0; m_has_ref = 0;
    endtask

    task automatic test_basic();
        logic err;
        offer(12'h123, err);
        n_checks++; if (err !== 1'b0) $display("FAIL basic_err_ref got=%b exp=0", err); else n_pass++;
        next_cycle();
        n_checks++; if (d_valid !== 1'b0) $display("FAIL basic_no_delta_after_ref got=%b exp=0", d_valid); else n_pass++;
        offer(12'h150, err);
        n_checks++; if (d_valid !== 1'b0) $display("FAIL basic_early_valid got=%b exp=0", d_valid); else n_pass++;
        next_cycle();
        n_checks++; if (d_valid !== 1'b1) $display("FAIL basic_valid_n2 got=%b exp=1", d_valid); else n_pass++;
        n_checks++; if (d_obs !== 12'h027) $display("FAIL basic_delta got=%h exp=027", d_obs); else n_pass++;
        n_checks++; if (d_neg !== 1'b0) $display("FAIL basic_neg got=%b exp=0", d_neg); else n_pass++;
        n_checks++; if (bcd_err !== 1'b0) $display("FAIL basic_bcd_err got=%b exp=0", bcd_err); else n_pass++;
        handshake();
        n_checks++; if (d_count !== CNT_W'(m_count)) $display("FAIL basic_count got=%0d exp=%0d", d_count, m_count); else n_pass++;
        n_checks++; if (d_valid !== 1'b0) $display("FAIL basic_valid_drop got=%b exp=0", d_valid); else n_pass++;
    endtask

    task automatic test_negative();
        int pairs [2][2] = '{'{500, 498}, '{905, 99}};
        logic err;
        for (int i = 0; i < 2; i++) begin
            do_clear();
            offer(to_bcd(pairs[i][0]), err);
            offer(to_bcd(pairs[i][1]), err);
            next_cycle();
            n_checks++; if (d_valid !== 1'b1) $display("FAIL neg_valid[%0d] got=%b exp=1", i, d_valid); else n_pass++;
            n_checks++; if (d_obs !== to_bcd(abs_diff(pairs[i][0], pairs[i][1])))
                $display("FAIL neg_delta[%0d] got=%h exp=%h", i, d_obs, to_bcd(abs_diff(pairs[i][0], pairs[i][1]))); else n_pass++;
            n_checks++; if (d_neg !== 1'b1) $display("FAIL neg_sign[%0d] got=%b exp=1", i, d_neg); else n_pass++;
            handshake();
        end
    endtask

    task automatic test_equal();
        logic err;
        do_clear();
        offer(12'h777, err);
        offer(12'h777, err);
        next_cycle();
        n_checks++; if (d_obs !== 12'h000) $display("FAIL equal_delta got=%h exp=000", d_obs); else n_pass++;
        n_checks++; if (d_neg !== 1'b0) $display("FAIL equal_neg got=%b exp=0", d_neg); else n_pass++;
        repeat (3) next_cycle();
        n_checks++; if (d_count !== CNT_W'(m_count)) $display("FAIL equal_count_held got=%0d exp=%0d", d_count, m_count); else n_pass++;
        n_checks++; if (d_valid !== 1'b1) $display("FAIL equal_valid_held got=%b exp=1", d_valid); else n_pass++;
        handshake();
        n_checks++; if (d_count !== CNT_W'(m_count)) $display("FAIL equal_count_inc got=%0d exp=%0d", d_count, m_count); else n_pass++;
    endtask

    task automatic test_bcd_err();
        logic err;
        do_clear();
        offer(12'h200, err);
        offer(12'h1A3, err);
        n_checks++; if (err !== 1'b1) $display("FAIL err_pulse got=%b exp=1", err); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL err_state_kept got=%b exp=1", s_ready); else n_pass++;
        d_ready = 1'b1;
        next_cycle();
        d_ready = 1'b0;
        n_checks++; if (bcd_err !== 1'b0) $display("FAIL err_one_cycle got=%b exp=0", bcd_err); else n_pass++;
        n_checks++; if (d_valid !== 1'b0) $display("FAIL err_no_delta got=%b exp=0", d_valid); else n_pass++;
        n_checks++; if (d_count !== CNT_W'(m_count)) $display("FAIL ready_idle_count got=%0d exp=%0d", d_count, m_count); else n_pass++;
        offer(12'h250, err);
        next_cycle();
        n_checks++; if (d_obs !== 12'h050) $display("FAIL err_follow_delta got=%h exp=050", d_obs); else n_pass++;
        n_checks++; if (d_neg !== 1'b0) $display("FAIL err_follow_neg got=%b exp=0", d_neg); else n_pass++;
        handshake();
    endtask

    task automatic test_stall_saturate();
        logic err;
        logic [11:0] held_d;
        logic held_neg;
        int v;
        do_clear();
        m_ref = 205;
        offer(to_bcd(m_ref), err);
        for (int k = 1; k <= 5; k++) begin
            v = $urandom_range(0, 999);
            offer(to_bcd(v), err);
            next_cycle();
            n_checks++; if (d_obs !== to_bcd(abs_diff(m_ref, v)) || d_neg !== (v < m_ref))
                $display("FAIL stall_delta[%0d] got=%h/%b exp=%h/%b", k, d_obs, d_neg, to_bcd(abs_diff(m_ref, v)), v < m_ref); else n_pass++;
            m_ref = v;
            if (k == 1) begin
                held_d = d_obs; held_neg = d_neg;
                {s_huns, s_tens, s_ones} = to_bcd($urandom_range(0, 999));
                s_valid = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    next_cycle();
                    n_checks++; if (s_ready !== 1'b0 || d_valid !== 1'b1 || d_obs !== held_d || d_neg !== held_neg)
                        $display("FAIL stall_hold[%0d] got=rdy%b v%b %h/%b exp=rdy0 v1 %h/%b", c, s_ready, d_valid, d_obs, d_neg, held_d, held_neg); else n_pass++;
                end
                s_valid = 1'b0;
            end
            handshake();
            n_checks++; if (d_count !== CNT_W'(m_count)) $display("FAIL sat_count[%0d] got=%0d exp=%0d", k, d_count, m_count); else n_pass++;
        end
    endtask

    task automatic test_clear_handshake();
        logic err;
        do_clear();
        offer(12'h300, err);
        offer(12'h310, err);
        next_cycle();
        handshake();
        offer(12'h100, err);
        next_cycle();
        n_checks++; if (d_neg !== 1'b1 || d_valid !== 1'b1) $display("FAIL clr_pre got=v%b n%b exp=v1 n1", d_valid, d_neg); else n_pass++;
        clear = 1'b1; d_ready = 1'b1;
        #1;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL clr_s_ready got=%b exp=0", s_ready); else n_pass++;
        next_cycle();
        clear = 1'b0; d_ready = 1'b0;
        m_count = 0; m_has_ref = 0;
        n_checks++; if (d_valid !== 1'b0 || d_neg !== 1'b0) $display("FAIL clr_outputs got=v%b n%b exp=v0 n0", d_valid, d_neg); else n_pass++;
        n_checks++; if (d_count !== CNT_W'(m_count)) $display("FAIL clr_count got=%0d exp=%0d", d_count, m_count); else n_pass++;
        offer(12'h400, err);
        next_cycle();
        next_cycle();
        n_checks++; if (d_valid !== 1'b0) $display("FAIL clr_no_delta got=%b exp=0", d_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic err;
        offer(12'h420, err);
        next_cycle();
        handshake();
        for (int phase = 0; phase < 2; phase++) begin
            offer(12'h450, err);
            if (phase == 1) next_cycle();
            rst_n = 1'b0;
            #2;
            n_checks++; if (d_valid !== 1'b0 || d_obs !== 12'h000 || d_neg !== 1'b0 || d_count !== '0 || s_ready !== 1'b1)
                $display("FAIL mid_reset[%0d] got=v%b d%h n%b c%0d r%b exp=v0 d000 n0 c0 r1", phase, d_valid, d_obs, d_neg, d_count, s_ready); else n_pass++;
            #2;
            rst_n = 1'b1;
            m_count = 0; m_has_ref = 0;
            next_cycle();
            offer(12'h600, err);
            next_cycle();
            next_cycle();
            n_checks++; if (d_valid !== 1'b0) $display("FAIL mid_reset_ref_drop[%0d] got=%b exp=0", phase, d_valid); else n_pass++;
        end
        m_has_ref = 1; m_ref = 600;
    endtask

    task automatic test_random();
        logic err;
        logic [11:0] s;
        int v;
        bit bad;
        do_clear();
        for (int i = 0; i < 60; i++) begin
            v = $urandom_range(0, 999);
            s = to_bcd(v);
            bad = ($urandom_range(0, 9) == 0);
            if (bad) begin
                case ($urandom_range(0, 2))
                    0: s[3:0]  = 4'($urandom_range(10, 15));
                    1: s[7:4]  = 4'($urandom_range(10, 15));
                    default: s[11:8] = 4'($urandom_range(10, 15));
                endcase
            end
            offer(s, err);
            n_checks++; if (err !== bad) $display("FAIL rnd_err[%0d] got=%b exp=%b", i, err, bad); else n_pass++;
            if (!bad) begin
                next_cycle();
                if (!m_has_ref) begin
                    n_checks++; if (d_valid !== 1'b0) $display("FAIL rnd_first[%0d] got=%b exp=0", i, d_valid); else n_pass++;
                    m_has_ref = 1;
                end else begin
                    n_checks++; if (d_valid !== 1'b1 || d_obs !== to_bcd(abs_diff(m_ref, v)) || d_neg !== (v < m_ref))
                        $display("FAIL rnd_delta[%0d] got=v%b %h/%b exp=v1 %h/%b", i, d_valid, d_obs, d_neg, to_bcd(abs_diff(m_ref, v)), v < m_ref); else n_pass++;
                    repeat ($urandom_range(0, 2)) next_cycle();
                    handshake();
                    n_checks++; if (d_count !== CNT_W'(m_count)) $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, d_count, m_count); else n_pass++;
                end
                m_ref = v;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_equal();
        test_bcd_err();
        test_stall_saturate();
        test_clear_handshake();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
